// File: rtl/fir_cfg_master_pkg.sv
// Shared types and register map for the FIR configuration master.
// Register offsets, ap_ctrl bit positions, FSM states and error codes.
package fir_cfg_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_WR,
    S_COEF_RD,
    S_COEF_WR,
    S_CHK_AR,
    S_CHK_R,
    S_START_WR,
    S_POLL_AR,
    S_POLL_R,
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TAP     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  localparam int REG_AP_CTRL  = 'h00;
  localparam int REG_DATA_LEN = 'h10;
  localparam int REG_TAP_BASE = 'h20;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  function automatic int tap_offset(input int idx);
    return REG_TAP_BASE + 4 * idx;
  endfunction

endpackage

// File: rtl/fir_axil_xact.sv
// AXI-Lite single-transaction engine: one write or read per req pulse.
// o_ack pulses once both write handshakes, or the read data beat, complete.
module fir_axil_xact #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_ack,
  output logic [DW-1:0] o_rdata,
  output logic          o_awvalid,
  output logic [AW-1:0] o_awaddr,
  input  logic          i_awready,
  output logic          o_wvalid,
  output logic [DW-1:0] o_wdata,
  input  logic          i_wready,
  output logic          o_arvalid,
  output logic [AW-1:0] o_araddr,
  input  logic          i_arready,
  output logic          o_rready,
  input  logic          i_rvalid,
  input  logic [DW-1:0] i_rdata
);

  logic          r_busy;
  logic          r_we;
  logic          r_ack;
  logic          r_aw_done;
  logic          r_w_done;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_arvalid;
  logic          r_rready;
  logic [AW-1:0] r_awaddr;
  logic [AW-1:0] r_araddr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_fin;

  assign w_aw_hs  = r_awvalid & i_awready;
  assign w_w_hs   = r_wvalid & i_wready;
  // aw and w may finish on different cycles
  assign w_wr_fin = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_ack     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      r_ack <= 1'b0;
      if (!r_busy) begin
        if (i_req) begin
          r_busy <= 1'b1;
          r_we   <= i_we;
          if (i_we) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= i_addr;
            r_wdata   <= i_wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_arvalid <= 1'b1;
            r_rready  <= 1'b1;
            r_araddr  <= i_addr;
          end
        end
      end else if (r_we) begin
        if (w_aw_hs) begin
          r_awvalid <= 1'b0;
          r_aw_done <= 1'b1;
        end
        if (w_w_hs) begin
          r_wvalid <= 1'b0;
          r_w_done <= 1'b1;
        end
        if (w_wr_fin) begin
          r_ack  <= 1'b1;
          r_busy <= 1'b0;
        end
      end else begin
        if (r_arvalid && i_arready)
          r_arvalid <= 1'b0;
        if (r_rready && i_rvalid) begin
          r_rdata  <= i_rdata;
          r_rready <= 1'b0;
          r_ack    <= 1'b1;
          r_busy   <= 1'b0;
        end
      end
    end
  end

  assign o_ack     = r_ack;
  assign o_rdata   = r_rdata;
  assign o_awvalid = r_awvalid;
  assign o_awaddr  = r_awaddr;
  assign o_wvalid  = r_wvalid;
  assign o_wdata   = r_wdata;
  assign o_arvalid = r_arvalid;
  assign o_araddr  = r_araddr;
  assign o_rready  = r_rready;

endmodule

// File: rtl/fir_cfg_master.sv
// FIR configuration sequencer: length, taps, tap readback, ap_start, poll.
// Each bus access goes through fir_axil_xact, one at a time.
module fir_cfg_master
  import fir_cfg_master_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_MAX    = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [pDATA_WIDTH-1:0] data_len,
  output logic [pADDR_WIDTH-1:0] coef_A,
  input  logic [pDATA_WIDTH-1:0] coef_Do,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  output logic                   rready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code
);

  localparam int IDX_W = $clog2(Tape_Num) + 1;
  localparam int PW    = $clog2(POLL_MAX + 1);

  state_e                 r_state;
  err_e                   r_err_code;
  logic [IDX_W-1:0]       r_idx;
  logic [PW-1:0]          r_poll;
  logic                   r_issued;
  logic                   r_req;
  logic                   r_we;
  logic [pADDR_WIDTH-1:0] r_addr;
  logic [pDATA_WIDTH-1:0] r_wdata;
  logic [pADDR_WIDTH-1:0] r_coef_A;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic                   w_ack;
  logic [pDATA_WIDTH-1:0] w_rdata;
  logic                   w_last;
  logic [pADDR_WIDTH-1:0] w_tap_addr;
  logic [pADDR_WIDTH-1:0] w_next_a;

  assign w_last     = (r_idx == IDX_W'(Tape_Num - 1));
  assign w_tap_addr = pADDR_WIDTH'(tap_offset(int'(r_idx)));
  assign w_next_a   = pADDR_WIDTH'(r_idx + IDX_W'(1));

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state    <= S_IDLE;
      r_err_code <= ERR_NONE;
      r_idx      <= '0;
      r_poll     <= '0;
      r_issued   <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_coef_A   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LEN_WR;
            r_busy     <= 1'b1;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_idx      <= '0;
            r_poll     <= '0;
            r_issued   <= 1'b0;
            r_wdata    <= data_len;
          end
        end
        S_LEN_WR: begin
          if (!r_issued) begin
            r_req    <= 1'b1;
            r_we     <= 1'b1;
            r_addr   <= pADDR_WIDTH'(REG_DATA_LEN);
            r_issued <= 1'b1;
          end else if (w_ack) begin
            r_issued <= 1'b0;
            r_coef_A <= '0;
            r_state  <= S_COEF_RD;
          end
        end
        S_COEF_RD: r_state <= S_COEF_WR;
        S_COEF_WR: begin
          // ROM word for r_idx is valid on the first COEF_WR cycle
          if (!r_issued) begin
            r_req    <= 1'b1;
            r_we     <= 1'b1;
            r_addr   <= w_tap_addr;
            r_wdata  <= coef_Do;
            r_issued <= 1'b1;
          end else if (w_ack) begin
            r_issued <= 1'b0;
            if (w_last) begin
              r_idx    <= '0;
              r_coef_A <= '0;
              r_state  <= S_CHK_AR;
            end else begin
              r_idx    <= r_idx + IDX_W'(1);
              r_coef_A <= w_next_a;
              r_state  <= S_COEF_RD;
            end
          end
        end
        S_CHK_AR: begin
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= w_tap_addr;
          r_state <= S_CHK_R;
        end
        S_CHK_R: begin
          if (w_ack) begin
            if (w_rdata != coef_Do) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_TAP;
              r_state    <= S_ERR;
            end else if (w_last) begin
              r_state <= S_START_WR;
            end else begin
              r_idx    <= r_idx + IDX_W'(1);
              r_coef_A <= w_next_a;
              r_state  <= S_CHK_AR;
            end
          end
        end
        S_START_WR: begin
          if (!r_issued) begin
            r_req    <= 1'b1;
            r_we     <= 1'b1;
            r_addr   <= pADDR_WIDTH'(REG_AP_CTRL);
            r_wdata  <= pDATA_WIDTH'(1 << AP_START_BIT);
            r_issued <= 1'b1;
          end else if (w_ack) begin
            r_issued <= 1'b0;
            r_poll   <= '0;
            r_state  <= S_POLL_AR;
          end
        end
        S_POLL_AR: begin
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= pADDR_WIDTH'(REG_AP_CTRL);
          r_state <= S_POLL_R;
        end
        S_POLL_R: begin
          if (w_ack) begin
            if (r_poll != PW'(POLL_MAX))
              r_poll <= r_poll + PW'(1);
            if (w_rdata[AP_DONE_BIT]) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_poll >= PW'(POLL_MAX - 1)) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_TIMEOUT;
              r_state    <= S_ERR;
            end else begin
              r_state <= S_POLL_AR;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  fir_axil_xact #(
    .AW(pADDR_WIDTH),
    .DW(pDATA_WIDTH)
  ) u_xact (
    .i_clk    (axis_clk),
    .i_rst    (axis_rst),
    .i_req    (r_req),
    .i_we     (r_we),
    .i_addr   (r_addr),
    .i_wdata  (r_wdata),
    .o_ack    (w_ack),
    .o_rdata  (w_rdata),
    .o_awvalid(awvalid),
    .o_awaddr (awaddr),
    .i_awready(awready),
    .o_wvalid (wvalid),
    .o_wdata  (wdata),
    .i_wready (wready),
    .o_arvalid(arvalid),
    .o_araddr (araddr),
    .i_arready(arready),
    .o_rready (rready),
    .i_rvalid (rvalid),
    .i_rdata  (rdata)
  );

  assign coef_A   = r_coef_A;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master with an AXI-Lite slave and ROM model.
// Slave readies/data change on negedge; handshakes are logged on posedge.
module tb_fir_cfg_master;
  import fir_cfg_master_pkg::*;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        start;
  logic [31:0] data_len;
  logic [11:0] coef_A;
  logic [31:0] coef_Do;
  logic        awvalid, awready, wvalid, wready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        arvalid, arready, rready, rvalid;
  logic        busy, done, error;
  logic [1:0]  err_code;

  fir_cfg_master #(
    .pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11), .POLL_MAX(8)
  ) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .start(start),
    .data_len(data_len), .coef_A(coef_A), .coef_Do(coef_Do),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rready(rready), .rvalid(rvalid), .rdata(rdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  initial forever #5 axis_clk = ~axis_clk;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] rom [16];
  int aw_delay = 0, w_delay = 0, corrupt_idx = -1, done_after = 5;

  int          aw_cnt, w_cnt, poll_reads;
  logic        got_aw, got_w, rd_pend;
  logic        hs_aw, hs_w, hs_ar;
  logic [11:0] wa;
  logic [31:0] wd, rd_val;
  logic [31:0] mem [16];
  logic [11:0] wr_addr [256];
  logic [31:0] wr_data [256];
  logic [11:0] rd_addr [256];
  int wr_n = 0, rd_n = 0, done_cnt = 0, viol = 0, skew_cyc = 0;

  always @(posedge axis_clk) coef_Do <= rom[coef_A[3:0]];

  always @(posedge axis_clk) begin
    hs_aw = 1'b0; hs_w = 1'b0; hs_ar = 1'b0;
    if (axis_rst) begin
      got_aw = 1'b0; got_w = 1'b0; rd_pend = 1'b0;
    end else begin
      if (awvalid && awready) begin wa = awaddr; got_aw = 1'b1; hs_aw = 1'b1; end
      if (wvalid && wready) begin wd = wdata; got_w = 1'b1; hs_w = 1'b1; end
      if (got_aw && got_w) begin
        got_aw = 1'b0; got_w = 1'b0;
        if (wr_n < 256) begin wr_addr[wr_n] = wa; wr_data[wr_n] = wd; end
        wr_n++;
        if (wa >= 12'h20 && wa < 12'h60) mem[4'((wa - 12'h20) >> 2)] = wd;
        if (wa == 12'h0) poll_reads = 0;
      end
      if (rvalid && rready) rd_pend = 1'b0;
      if (arvalid && arready) begin
        hs_ar = 1'b1;
        if (rd_n < 256) rd_addr[rd_n] = araddr;
        rd_n++;
        rd_pend = 1'b1;
        if (araddr == 12'h0) begin
          poll_reads++;
          rd_val = (done_after != 0 && poll_reads >= done_after) ? 32'h2 : 32'h0;
        end else if (int'((araddr - 12'h20) >> 2) == corrupt_idx) begin
          rd_val = 32'h5;
        end else begin
          rd_val = mem[4'((araddr - 12'h20) >> 2)];
        end
      end
    end
  end

  always @(negedge axis_clk) begin
    if (axis_rst) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0;
      rdata = '0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (!awvalid) begin awready = 1'b0; aw_cnt = 0; end
      else if (aw_cnt >= aw_delay) awready = 1'b1;
      else begin awready = 1'b0; aw_cnt++; end
      if (!wvalid) begin wready = 1'b0; w_cnt = 0; end
      else if (w_cnt >= w_delay) wready = 1'b1;
      else begin wready = 1'b0; w_cnt++; end
      arready = arvalid && !rd_pend;
      rvalid  = rd_pend && rready;
      rdata   = rd_val;
      if (done) done_cnt++;
      if ((awvalid || wvalid) && (arvalid || rready)) viol++;
      if ((hs_aw && awvalid) || (hs_w && wvalid) || (hs_ar && arvalid)) viol++;
      if (wvalid && !awvalid) skew_cyc++;
    end
  end

  task automatic pulse_start(input logic [31:0] len);
    @(negedge axis_clk);
    data_len = len;
    start = 1'b1;
    @(negedge axis_clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin to = 1'b0; break; end
      @(negedge axis_clk);
    end
  endtask

  task automatic test_reset;
    axis_rst = 1'b0;
    #1 axis_rst = 1'b1;
    repeat (2) @(negedge axis_clk);
    n_run++;
    if ({awvalid, wvalid, arvalid, rready, busy, done, error} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {awvalid, wvalid, arvalid, rready, busy, done, error});
    end
    n_run++;
    if ({awaddr, araddr, coef_A, err_code} !== 38'b0) begin
      n_fail++;
      $display("FAIL reset_addr: aw=%h ar=%h coef_A=%h err=%0d want 0",
               awaddr, araddr, coef_A, err_code);
    end
    n_run++;
    if (wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wdata: got %h want 0", wdata);
    end
    @(negedge axis_clk);
    axis_rst = 1'b0;
    repeat (2) @(negedge axis_clk);
  endtask

  task automatic test_nominal;
    int wb, rb, db, vb;
    bit to;
    aw_delay = 0; w_delay = 0; corrupt_idx = -1; done_after = 5;
    wb = wr_n; rb = rd_n; db = done_cnt; vb = viol;
    pulse_start(32'd600);
    wait_idle(3000, to);
    n_run++;
    if (to) begin n_fail++; $display("FAIL nom_timeout: busy=%b want 0", busy); end
    n_run++;
    if (wr_n - wb != 13) begin
      n_fail++; $display("FAIL nom_wr_count: got %0d want 13", wr_n - wb);
    end
    n_run++;
    if ({wr_addr[wb], wr_data[wb]} !== {12'h10, 32'd600}) begin
      n_fail++;
      $display("FAIL nom_len_wr: got %h/%0d want 010/600", wr_addr[wb], wr_data[wb]);
    end
    for (int i = 0; i < 11; i++) begin
      n_run++;
      if ({wr_addr[wb+1+i], wr_data[wb+1+i]} !== {12'(32'h20 + 4 * i), rom[i]}) begin
        n_fail++;
        $display("FAIL nom_tap_wr[%0d]: got %h/%h want %h/%h", i, wr_addr[wb+1+i],
                 wr_data[wb+1+i], 12'(32'h20 + 4 * i), rom[i]);
      end
    end
    n_run++;
    if ({wr_addr[wb+12], wr_data[wb+12]} !== {12'h0, 32'h1}) begin
      n_fail++;
      $display("FAIL nom_start_wr: got %h/%h want 000/1", wr_addr[wb+12], wr_data[wb+12]);
    end
    n_run++;
    if (rd_n - rb != 16) begin
      n_fail++; $display("FAIL nom_rd_count: got %0d want 16", rd_n - rb);
    end
    for (int i = 0; i < 16; i++) begin
      n_run++;
      if (rd_addr[rb+i] !== ((i < 11) ? 12'(32'h20 + 4 * i) : 12'h0)) begin
        n_fail++;
        $display("FAIL nom_rd_addr[%0d]: got %h", i, rd_addr[rb+i]);
      end
    end
    n_run++;
    if (done_cnt - db != 1) begin
      n_fail++; $display("FAIL nom_done_cycles: got %0d want 1", done_cnt - db);
    end
    n_run++;
    if ({error, err_code} !== 3'b0) begin
      n_fail++; $display("FAIL nom_error: got %b/%0d want 0/0", error, err_code);
    end
    n_run++;
    if (viol != vb) begin
      n_fail++; $display("FAIL nom_protocol: got %0d violations want 0", viol - vb);
    end
  endtask

  task automatic test_write_skew;
    int wb, db, vb, sb;
    bit to;
    aw_delay = 0; w_delay = 3; corrupt_idx = -1; done_after = 5;
    wb = wr_n; db = done_cnt; vb = viol; sb = skew_cyc;
    pulse_start(32'd600);
    wait_idle(3000, to);
    n_run++;
    if (to) begin n_fail++; $display("FAIL skew_timeout: busy=%b want 0", busy); end
    n_run++;
    if (skew_cyc - sb != 39) begin
      n_fail++; $display("FAIL skew_cycles: got %0d want 39", skew_cyc - sb);
    end
    n_run++;
    if (viol != vb) begin
      n_fail++; $display("FAIL skew_protocol: got %0d violations want 0", viol - vb);
    end
    n_run++;
    if (wr_n - wb != 13 || done_cnt - db != 1) begin
      n_fail++;
      $display("FAIL skew_result: writes %0d done %0d want 13/1", wr_n - wb, done_cnt - db);
    end
    w_delay = 0;
  endtask

  task automatic test_tap_mismatch;
    int wb, rb, db, zw;
    bit to;
    corrupt_idx = 4; done_after = 5;
    wb = wr_n; rb = rd_n; db = done_cnt;
    pulse_start(32'd600);
    wait_idle(3000, to);
    zw = 0;
    for (int i = wb; i < wr_n && i < 256; i++) if (wr_addr[i] == 12'h0) zw++;
    n_run++;
    if (to) begin n_fail++; $display("FAIL mis_timeout: busy=%b want 0", busy); end
    n_run++;
    if ({error, err_code} !== 3'b101) begin
      n_fail++; $display("FAIL mis_error: got %b/%0d want 1/1", error, err_code);
    end
    n_run++;
    if (zw != 0 || wr_n - wb != 12) begin
      n_fail++; $display("FAIL mis_writes: ctrl %0d total %0d want 0/12", zw, wr_n - wb);
    end
    n_run++;
    if (rd_n - rb != 5) begin
      n_fail++; $display("FAIL mis_reads: got %0d want 5", rd_n - rb);
    end
    n_run++;
    if (done_cnt != db) begin
      n_fail++; $display("FAIL mis_done: got %0d pulses want 0", done_cnt - db);
    end
    corrupt_idx = -1;
  endtask

  task automatic test_poll_timeout;
    int rb, db, pr;
    bit to;
    corrupt_idx = -1; done_after = 0;
    rb = rd_n; db = done_cnt;
    pulse_start(32'd600);
    n_run++;
    if ({error, err_code} !== 3'b0) begin
      n_fail++; $display("FAIL to_err_clear: got %b/%0d want 0/0", error, err_code);
    end
    wait_idle(3000, to);
    pr = 0;
    for (int i = rb; i < rd_n && i < 256; i++) if (rd_addr[i] == 12'h0) pr++;
    n_run++;
    if (to) begin n_fail++; $display("FAIL to_timeout: busy=%b want 0", busy); end
    n_run++;
    if (pr != 8 || rd_n - rb != 19) begin
      n_fail++; $display("FAIL to_polls: got %0d/%0d want 8/19", pr, rd_n - rb);
    end
    n_run++;
    if ({error, err_code} !== 3'b110) begin
      n_fail++; $display("FAIL to_error: got %b/%0d want 1/2", error, err_code);
    end
    n_run++;
    if (done_cnt != db) begin
      n_fail++; $display("FAIL to_done: got %0d pulses want 0", done_cnt - db);
    end
    done_after = 5;
  endtask

  task automatic test_busy_and_reset;
    int wb, db, lw;
    bit to, found;
    corrupt_idx = -1; done_after = 5;
    wb = wr_n;
    pulse_start(32'd600);
    repeat (4) @(negedge axis_clk);
    pulse_start(32'd77);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (awvalid && awaddr == 12'h28) begin found = 1'b1; break; end
      @(negedge axis_clk);
    end
    n_run++;
    if (!found) begin n_fail++; $display("FAIL rst_find_tap2: got none want awaddr 028"); end
    lw = 0;
    for (int i = wb; i < wr_n && i < 256; i++) if (wr_addr[i] == 12'h10) lw++;
    n_run++;
    if (lw != 1 || wr_data[wb] !== 32'd600) begin
      n_fail++; $display("FAIL busy_start_ignored: len writes %0d data %0d want 1/600",
                         lw, wr_data[wb]);
    end
    #2 axis_rst = 1'b1;
    #1;
    n_run++;
    if ({awvalid, wvalid, arvalid, rready, busy, done} !== 6'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b want 000000",
                         {awvalid, wvalid, arvalid, rready, busy, done});
    end
    n_run++;
    if (dut.r_state !== S_IDLE) begin
      n_fail++; $display("FAIL rst_mid_state: got %0d want IDLE", dut.r_state);
    end
    @(negedge axis_clk);
    axis_rst = 1'b0;
    @(negedge axis_clk);
    wb = wr_n; db = done_cnt;
    pulse_start(32'd600);
    wait_idle(3000, to);
    n_run++;
    if (to) begin n_fail++; $display("FAIL rst_restart_timeout: busy=%b want 0", busy); end
    n_run++;
    if ({wr_addr[wb], wr_data[wb]} !== {12'h10, 32'd600} || wr_n - wb != 13) begin
      n_fail++; $display("FAIL rst_restart: first %h/%0d count %0d want 010/600/13",
                         wr_addr[wb], wr_data[wb], wr_n - wb);
    end
    n_run++;
    if (done_cnt - db != 1) begin
      n_fail++; $display("FAIL rst_restart_done: got %0d want 1", done_cnt - db);
    end
  endtask

  initial begin
    logic [31:0] taps [11];
    taps = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63,
             32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};
    for (int i = 0; i < 16; i++) rom[i] = (i < 11) ? taps[i] : 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    start = 1'b0;
    data_len = '0;
    poll_reads = 0;
    rd_val = '0;
    test_reset();
    test_nominal();
    test_write_skew();
    test_tap_mismatch();
    test_poll_timeout();
    test_busy_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
